// File: rtl/adc_agc_ctrl.sv
// adc_agc_ctrl: automatic gain control for one ADC channel.
// Measures the peak |sample| over a programmable window and moves a
// 5-level gain ladder (att, amp_en) up or down. Each level change is
// followed by a settle hold-off. When enable is low, the manual settings
// pass through.
// Optional build macro AGC_DOR_FASTATTACK_EN: the ADC overrange flag forces
// an immediate attenuation step.
module adc_agc_ctrl #(
    parameter int WIDTH       = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int LEVEL_RESET = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [1:0]           man_att,
    input  logic                 man_amp_en,
    input  logic [CNT_WIDTH-1:0] window_len,
    input  logic [CNT_WIDTH-1:0] settle_cycles,
    input  logic [WIDTH-1:0]     hi_thresh,
    input  logic [WIDTH-1:0]     lo_thresh,
    input  logic [WIDTH-1:0]     in,
    input  logic                 valid_in,
    input  logic                 dor_in,
    output logic [1:0]           att,
    output logic                 amp_en,
    output logic [2:0]           level,
    output logic                 step_up,
    output logic                 step_down,
    output logic [WIDTH-1:0]     peak
);

    typedef enum logic [1:0] {IDLE, MEASURE, DECIDE, SETTLE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           level_q, level_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     peak_q, peak_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] scnt_q, scnt_d;
    logic [CNT_WIDTH-1:0] wlast_q, wlast_d;
    logic                 up_q, up_d, dn_q, dn_d;
    logic [1:0]           map_att;
    logic                 map_amp;
    logic [WIDTH-1:0]     sample_abs;
    logic [WIDTH-1:0]     acc_max;
    logic [CNT_WIDTH-1:0] wlast_load;
    logic                 dor_hit;

    // |x| as unsigned; the most negative code maps to 2^(WIDTH-1) without saturating
    assign sample_abs = in[WIDTH-1] ? (WIDTH'(0) - in) : in;
    assign acc_max    = (sample_abs > acc_q) ? sample_abs : acc_q;
    // index of the last sample in a window; a zero length behaves as one
    assign wlast_load = (window_len == '0) ? '0 : (window_len - CNT_WIDTH'(1));

`ifdef AGC_DOR_FASTATTACK_EN
    assign dor_hit = dor_in && ((state_q == MEASURE) || (state_q == DECIDE)) && (level_q < 3'd4);
`else
    // overrange flag has no effect in this build; the port stays for compatibility
    assign dor_hit = dor_in & 1'b0;
`endif

    // gain ladder: level -> front-end settings
    always_comb begin
        map_att = 2'd3;
        map_amp = 1'b0;
        case (level_q)
            3'd0:    begin map_att = 2'd0; map_amp = 1'b1; end
            3'd1:    begin map_att = 2'd0; map_amp = 1'b0; end
            3'd2:    begin map_att = 2'd1; map_amp = 1'b0; end
            3'd3:    begin map_att = 2'd2; map_amp = 1'b0; end
            default: begin map_att = 2'd3; map_amp = 1'b0; end
        endcase
    end

    // next-state logic: window measurement, decision, settle hold-off
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        acc_d   = acc_q;
        peak_d  = peak_q;
        cnt_d   = cnt_q;
        scnt_d  = scnt_q;
        wlast_d = wlast_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            scnt_d  = '0;
        end else if (dor_hit) begin
            // fast attack discards the window and pre-empts a pending decision
            level_d = level_q + 3'd1;
            up_d    = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            scnt_d  = settle_cycles;
            state_d = SETTLE;
        end else begin
            case (state_q)
                IDLE: begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    wlast_d = wlast_load;
                    state_d = MEASURE;
                end
                MEASURE: begin
                    if (valid_in) begin
                        acc_d = acc_max;
                        if (cnt_q == wlast_q) begin
                            cnt_d   = '0;
                            state_d = DECIDE;
                        end else begin
                            cnt_d = cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                DECIDE: begin
                    peak_d = acc_q;
                    acc_d  = '0;
                    cnt_d  = '0;
                    if ((acc_q > hi_thresh) && (level_q < 3'd4)) begin
                        level_d = level_q + 3'd1;
                        up_d    = 1'b1;
                        scnt_d  = settle_cycles;
                        state_d = SETTLE;
                    end else if ((acc_q < lo_thresh) && (level_q != 3'd0)) begin
                        level_d = level_q - 3'd1;
                        dn_d    = 1'b1;
                        scnt_d  = settle_cycles;
                        state_d = SETTLE;
                    end else begin
                        wlast_d = wlast_load;
                        state_d = MEASURE;
                    end
                end
                SETTLE: begin
                    if (scnt_q == '0) begin
                        wlast_d = wlast_load;
                        state_d = MEASURE;
                    end else begin
                        scnt_d = scnt_q - CNT_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            level_q <= 3'(LEVEL_RESET);
            acc_q   <= '0;
            peak_q  <= '0;
            cnt_q   <= '0;
            scnt_q  <= '0;
            wlast_q <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            acc_q   <= acc_d;
            peak_q  <= peak_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            wlast_q <= wlast_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
        end
    end

    // front-end controls: ladder value when active, manual values otherwise
    always_ff @(posedge clk) begin
        if (!resetn) begin
            att    <= 2'd0;
            amp_en <= 1'b0;
        end else if (enable) begin
            att    <= map_att;
            amp_en <= map_amp;
        end else begin
            att    <= man_att;
            amp_en <= man_amp_en;
        end
    end

    assign level     = level_q;
    assign step_up   = up_q;
    assign step_down = dn_q;
    assign peak      = peak_q;

endmodule

// File: tb/tb_adc_agc_ctrl.sv
// tb_adc_agc_ctrl: directed table, hand sequences and random stimulus,
// with every output compared against a window-level reference model.
module tb_adc_agc_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [1:0]  man_att;
    logic        man_amp_en;
    logic [15:0] window_len;
    logic [15:0] settle_cycles;
    logic [7:0]  hi_thresh;
    logic [7:0]  lo_thresh;
    logic [7:0]  din;
    logic        valid_in;
    logic        dor_in;
    logic [1:0]  att;
    logic        amp_en;
    logic [2:0]  level;
    logic        step_up;
    logic        step_down;
    logic [7:0]  peak;

    adc_agc_ctrl #(.WIDTH(8), .CNT_WIDTH(16), .LEVEL_RESET(1)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .man_att(man_att),
        .man_amp_en(man_amp_en), .window_len(window_len),
        .settle_cycles(settle_cycles), .hi_thresh(hi_thresh),
        .lo_thresh(lo_thresh), .in(din), .valid_in(valid_in), .dor_in(dor_in),
        .att(att), .amp_en(amp_en), .level(level), .step_up(step_up),
        .step_down(step_down), .peak(peak)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 collecting a window, 2 deciding, 3 settling
    int m_phase, m_level, m_att, m_amp, m_up, m_dn, m_peak, m_scnt, m_wlen;
    int m_win[$];

    always @(posedge clk) begin
        int s, pk;
        if (!resetn) begin
            m_phase = 0; m_level = 1; m_att = 0; m_amp = 0;
            m_up = 0; m_dn = 0; m_peak = 0; m_scnt = 0; m_wlen = 1;
            m_win.delete();
        end else begin
            if (enable) begin
                m_att = (m_level == 0) ? 0 : m_level - 1;
                m_amp = (m_level == 0) ? 1 : 0;
            end else begin
                m_att = man_att;
                m_amp = man_amp_en;
            end
            m_up = 0; m_dn = 0;
            if (!enable) begin
                m_phase = 0;
                m_win.delete();
`ifdef AGC_DOR_FASTATTACK_EN
            end else if (dor_in && (m_phase == 1 || m_phase == 2) && m_level < 4) begin
                m_level++; m_up = 1; m_phase = 3; m_scnt = settle_cycles;
                m_win.delete();
`endif
            end else begin
                case (m_phase)
                    0: begin
                        m_phase = 1; m_win.delete();
                        m_wlen = (window_len == 0) ? 1 : int'(window_len);
                    end
                    1: if (valid_in) begin
                        s = $signed(din);
                        m_win.push_back(s < 0 ? -s : s);
                        if (m_win.size() == m_wlen) m_phase = 2;
                    end
                    2: begin
                        pk = 0;
                        foreach (m_win[k]) if (m_win[k] > pk) pk = m_win[k];
                        m_peak = pk;
                        m_win.delete();
                        if (pk > hi_thresh && m_level < 4) begin
                            m_level++; m_up = 1; m_phase = 3; m_scnt = settle_cycles;
                        end else if (pk < lo_thresh && m_level > 0) begin
                            m_level--; m_dn = 1; m_phase = 3; m_scnt = settle_cycles;
                        end else begin
                            m_phase = 1;
                            m_wlen = (window_len == 0) ? 1 : int'(window_len);
                        end
                    end
                    default: begin
                        if (m_scnt == 0) begin
                            m_phase = 1;
                            m_wlen = (window_len == 0) ? 1 : int'(window_len);
                        end else m_scnt--;
                    end
                endcase
            end
        end
    end

    task automatic check_model();
        chk("m_att", att, m_att);
        chk("m_amp_en", amp_en, m_amp);
        chk("m_level", level, m_level);
        chk("m_step_up", step_up, m_up);
        chk("m_step_down", step_down, m_dn);
        chk("m_peak", peak, m_peak);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    int last_up, last_dn;

    // n samples of +val (alternating sign when alt), decision edge, then settle time
    task automatic window(input int val, input int n, input bit alt);
        for (int k = 0; k < n; k++) begin
            valid_in = 1'b1;
            din = (alt && (k % 2 == 1)) ? 8'(-val) : 8'(val);
            step();
        end
        valid_in = 1'b0;
        step();
        last_up = step_up;
        last_dn = step_down;
        repeat (4) step();
    endtask

    typedef struct {
        bit v; int smp; int lvl; bit up; int att; bit amp; int pk;
    } vec_t;
    vec_t tbl[11];

    int exp_lvl;
    bit dor_on;

    initial begin
`ifdef AGC_DOR_FASTATTACK_EN
        dor_on = 1'b1;
`else
        dor_on = 1'b0;
`endif
        //            v  smp   lvl up att amp pk
        tbl[0]  = '{0, 0,    1, 0, 0, 0, 0};
        tbl[1]  = '{1, 10,   1, 0, 0, 0, 0};
        tbl[2]  = '{1, -128, 1, 0, 0, 0, 0};
        tbl[3]  = '{1, 5,    1, 0, 0, 0, 0};
        tbl[4]  = '{1, 0,    1, 0, 0, 0, 0};
        tbl[5]  = '{0, 0,    2, 1, 0, 0, 128};
        tbl[6]  = '{1, 127,  2, 0, 1, 0, 128};
        tbl[7]  = '{1, 127,  2, 0, 1, 0, 128};
        tbl[8]  = '{1, 127,  2, 0, 1, 0, 128};
        tbl[9]  = '{1, 127,  2, 0, 1, 0, 128};
        tbl[10] = '{0, 0,    2, 0, 1, 0, 128};

        resetn = 1'b0; enable = 1'b0; man_att = 2'd0; man_amp_en = 1'b0;
        window_len = 16'd4; settle_cycles = 16'd8; hi_thresh = 8'd100;
        lo_thresh = 8'd20; din = 8'd0; valid_in = 1'b0; dor_in = 1'b0;
        step(); step();
        chk("rst_level", level, 1);
        chk("rst_att", att, 0);
        chk("rst_amp", amp_en, 0);
        chk("rst_peak", peak, 0);
        chk("rst_pulses", {step_up, step_down}, 0);

        // manual pass-through
        resetn = 1'b1; man_att = 2'd3; man_amp_en = 1'b1;
        step();
        chk("man_att", att, 3);
        chk("man_amp", amp_en, 1);
        chk("man_level", level, 1);

        // first window: peak of {10,-128,5,0} steps up, samples during settle ignored
        enable = 1'b1;
        foreach (tbl[i]) begin
            valid_in = tbl[i].v;
            din = 8'(tbl[i].smp);
            step();
            chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
            chk($sformatf("tbl%0d_up", i), step_up, tbl[i].up);
            chk($sformatf("tbl%0d_att", i), att, tbl[i].att);
            chk($sformatf("tbl%0d_amp", i), amp_en, tbl[i].amp);
            chk($sformatf("tbl%0d_peak", i), peak, tbl[i].pk);
        end
        valid_in = 1'b0;
        repeat (5) step();

        // walk down to level 0, then a quiet window at level 0 changes nothing
        settle_cycles = 16'd2;
        window(5, 4, 0); chk("dn_to_1", level, 1);
        window(5, 4, 0); chk("dn_to_0", level, 0); chk("amp_at_0", amp_en, 1);
        window(5, 4, 0);
        chk("l0_level", level, 0); chk("l0_no_dn", last_dn, 0); chk("l0_no_up", last_up, 0);

        // walk up to level 4, then a loud window at level 4 changes nothing
        for (int l = 1; l <= 4; l++) begin
            window(127, 4, 0);
            chk($sformatf("up_to_%0d", l), level, l);
        end
        window(127, 4, 0);
        chk("l4_level", level, 4); chk("l4_no_up", last_up, 0); chk("l4_att", att, 3);

        // small bipolar samples step back down
        window(3, 4, 1); chk("pm3_to_3", level, 3); chk("pm3_dn", last_dn, 1);
        window(3, 4, 1);
        chk("pm3_to_2", level, 2); chk("pm3_att", att, 1); chk("pm3_amp", amp_en, 0);
        chk("pm3_peak", peak, 3);

        // overrange mid-window
        valid_in = 1'b1; din = 8'd50; step(); step();
        valid_in = 1'b0; dor_in = 1'b1; step();
        dor_in = 1'b0;
        exp_lvl = dor_on ? 3 : 2;
        chk("dor_level", level, exp_lvl);
        chk("dor_up", step_up, int'(dor_on));
        repeat (5) step();
        chk("dor_att", att, exp_lvl - 1);
        chk("dor_peak", peak, 3);

        // enable dropped mid-window, then a fresh 16-sample window is needed
        window_len = 16'd16;
        enable = 1'b0; step(); enable = 1'b1; step();
        for (int k = 0; k < 8; k++) begin valid_in = 1'b1; din = 8'd127; step(); end
        valid_in = 1'b0; enable = 1'b0; man_att = 2'd2; man_amp_en = 1'b1;
        step();
        chk("dis_att", att, 2); chk("dis_amp", amp_en, 1); chk("dis_level", level, exp_lvl);
        step(); step();
        enable = 1'b1; step();
        for (int k = 0; k < 15; k++) begin valid_in = 1'b1; din = 8'd127; step(); end
        chk("fresh15_level", level, exp_lvl);
        step();
        valid_in = 1'b0; step();
        chk("fresh16_level", level, exp_lvl + 1);
        chk("fresh16_up", step_up, 1);
        repeat (6) step();

        // random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            resetn        = ($urandom_range(0, 299) != 0);
            enable        = ($urandom_range(0, 39) != 0);
            man_att       = 2'($urandom);
            man_amp_en    = 1'($urandom);
            window_len    = 16'($urandom_range(0, 5));
            settle_cycles = 16'($urandom_range(0, 3));
            hi_thresh     = 8'($urandom_range(60, 255));
            lo_thresh     = 8'($urandom_range(0, 60));
            din           = 8'($urandom);
            valid_in      = ($urandom_range(0, 9) < 7);
            dor_in        = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_agc_ctrl.md
Name: adc_agc_ctrl

Overview:
- Automatic gain controller for one ADC channel.
- Measures the peak absolute value of the raw 8-bit ADC samples over a programmable window.
- Steps the analog front end (attenuator att[1:0], amplifier amp_en) up or down through a 5-level gain ladder, with a settle hold-off after each change.
- Sits beside the channel datapath; its att/amp_en outputs replace the register-driven values when enabled, and the manual values pass through otherwise.

Parameters:
- WIDTH, 8, sample width (two's complement).
- CNT_WIDTH, 16, width of window and settle counters.
- LEVEL_RESET, 1, gain level loaded at reset (0..4).

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- enable  in  1  1 = AGC active, 0 = manual pass-through.
- man_att  in  2  manual attenuator setting.
- man_amp_en  in  1  manual amplifier enable.
- window_len  in  CNT_WIDTH  samples per measurement window; 0 treated as 1.
- settle_cycles  in  CNT_WIDTH  hold-off clocks after a level change.
- hi_thresh  in  WIDTH  unsigned peak threshold for stepping attenuation up.
- lo_thresh  in  WIDTH  unsigned peak threshold for stepping attenuation down.
- in  in  WIDTH  signed ADC sample.
- valid_in  in  1  sample qualifier.
- dor_in  in  1  ADC data-overrange flag.
- att  out  2  attenuator control, registered.
- amp_en  out  1  amplifier enable, registered.
- level  out  3  current gain level, 0 = max gain, 4 = min gain.
- step_up  out  1  one-cycle pulse: level incremented.
- step_down  out  1  one-cycle pulse: level decremented.
- peak  out  WIDTH  peak |in| of the last completed window.

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE, level=LEVEL_RESET, att=0, amp_en=0, step_up=step_down=0, peak=0, internal counters and accumulator 0.
- Level map (att, amp_en): 0→(0,1); 1→(0,0); 2→(1,0); 3→(2,0); 4→(3,0).
- Output update:
  - att/amp_en register from map(level) one cycle after level changes when enable=1.
  - When enable=0 they register from man_att/man_amp_en with 1-cycle latency.
- Abs: |x| as unsigned WIDTH bits; -128 → 128, no saturation needed.
- States:
  - IDLE:
    - Level held, accumulator cleared.
    - enable=1 → MEASURE.
  - MEASURE:
    - Each valid_in: acc<=max(acc,|in|), cnt++.
    - On the valid sample where cnt==max(window_len,1)-1 → DECIDE, with acc including that sample.
    - Cycles without valid_in do not count.
  - DECIDE (exactly 1 cycle):
    - peak<=acc.
    - If acc>hi_thresh and level<4: level+1, step_up=1 next cycle.
    - Else if acc<lo_thresh and level>0: level-1, step_down=1.
    - hi test takes priority when thresholds are inverted.
    - Changed → SETTLE with scnt=settle_cycles; unchanged → MEASURE.
    - acc and cnt are cleared in both cases.
    - Samples arriving during DECIDE are dropped.
  - SETTLE:
    - Samples ignored.
    - scnt decrements every clk; at scnt==0 → MEASURE.
    - settle_cycles=0 gives one SETTLE cycle.
- Latency: last window sample at edge T; DECIDE during T..T+1; level and step pulse update at edge T+1; att/amp_en update at edge T+2.
- Boundaries:
  - At level 4 with peak>hi, or level 0 with peak<lo: no change, no pulse, return to MEASURE.
  - enable deasserted in any state → IDLE at next edge; level held; pulses forced 0; an in-progress window is discarded.
  - enable asserted mid-operation always starts a fresh window.
  - window_len/settle_cycles changes take effect at the next window/settle load.
  - Reset mid-window discards the window and reloads LEVEL_RESET.
- step_up and step_down are never asserted together.

Optional Feature:
- Macro: AGC_DOR_FASTATTACK_EN.
- Defined:
  - dor_in=1 in MEASURE or DECIDE with level<4 → level+1 and step_up pulse at the next edge, then SETTLE.
  - Window discarded and peak not updated.
  - dor_in simultaneous with window completion gives a single step only; dor wins.
  - At level 4 dor_in is ignored.
  - dor_in in SETTLE/IDLE is ignored.
- Not defined: dor_in is ignored entirely; port retained.

Test Plan:
- Reset with LEVEL_RESET=1, then enable=0, man_att=3, man_amp_en=1 → att=3, amp_en=1 one cycle later; level=1.
- enable=1, window_len=4, hi=100, lo=20, samples {10,-128,5,0} → peak=128, step_up pulse, level 1→2, att=1 two cycles after last sample; next 4-sample window ignored during settle_cycles=8.
- Level 0, samples all 5 with lo=20 → no step_down, no pulse, returns to MEASURE; at level 4 with samples 127 and hi=100 → no step.
- enable=1, level=3, window of samples all ±3 with lo=20 → step_down, level=2, att=1, amp_en=0.
- enable dropped midway through a 16-sample window → IDLE next edge, att follows man_att, level unchanged; re-enable → full 16 fresh samples needed before the next decision.
- AGC_DOR_FASTATTACK_EN defined, level=2, dor_in pulse mid-window → level=3, att=2, window discarded, peak unchanged; undefined → no change.
